// File: rtl/fir_pkg.sv
// Shared definitions for the fir datapath: default widths, coefficient scaling
// and the tap-window state encoding.
package fir_pkg;

    localparam int unsigned FIR_DATA_W = 32;
    localparam int unsigned FIR_NTAPS  = 6;
    localparam int unsigned COEF_FRAC  = 12;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } win_state_t;

endpackage

// File: rtl/fir_shift_reg.sv
// NTAPS-deep sample delay line; slot 0 (low bits) holds the newest sample.
module fir_shift_reg
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = FIR_DATA_W,
    parameter int unsigned NTAPS  = FIR_NTAPS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    shift_en,
    input  logic [DATA_W-1:0]       shift_in,
    output logic [NTAPS*DATA_W-1:0] taps
);

    logic [NTAPS*DATA_W-1:0] chain_q;

    // Clear wins over shift so a same-cycle sample is discarded by a partial flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else if (clr) begin
            chain_q <= '0;
        end else if (shift_en) begin
            chain_q <= {chain_q[(NTAPS-1)*DATA_W-1:0], shift_in};
        end
    end

    assign taps = chain_q;

endmodule

// File: rtl/fir_tap_window.sv
// Sliding window feeder for the fir datapath: collects samples, presents the last
// NTAPS as parallel taps over valid/ready, and drains the tail with zeros on flush.
module fir_tap_window
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W     = FIR_DATA_W,
    parameter int unsigned NTAPS      = FIR_NTAPS,
    parameter bit          PRIME_ZERO = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    input  logic                    flush,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [NTAPS*DATA_W-1:0] taps,
    output logic                    flush_done
);

    localparam int unsigned         CNT_W     = $clog2(NTAPS + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(NTAPS - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(NTAPS);
    localparam win_state_t          RST_STATE = PRIME_ZERO ? RUN : FILL;

    win_state_t       state_q, state_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             m_valid_d;
    logic             flush_done_d;
    logic             accept;
    logic             shift_en;
    logic             shift_zero;
    logic             clr;
    logic [DATA_W-1:0] shift_in;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign s_ready  = rst_n && (state_q != FLUSH) && (!m_valid || m_ready);
    assign accept   = s_valid && s_ready;
    assign shift_in = shift_zero ? '0 : s_data;

    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        m_valid_d    = m_valid && !m_ready;
        flush_done_d = 1'b0;
        shift_en     = 1'b0;
        shift_zero   = 1'b0;
        clr          = 1'b0;

        case (state_q)
            FILL: begin
                if (accept) begin
                    shift_en   = 1'b1;
                    fill_cnt_d = sat_inc(fill_cnt_q);
                    if (fill_cnt_q == CNT_LAST) begin
                        m_valid_d = 1'b1;
                        state_d   = RUN;
                    end
                end
                // A sample that completes the window turns this into a full-window flush.
                if (flush) begin
                    if (accept && (fill_cnt_q == CNT_LAST)) begin
                        state_d     = FLUSH;
                        flush_cnt_d = '0;
                    end else begin
                        clr          = 1'b1;
                        fill_cnt_d   = '0;
                        flush_done_d = 1'b1;
                        state_d      = RST_STATE;
                    end
                end
            end

            RUN: begin
                if (accept) begin
                    shift_en  = 1'b1;
                    m_valid_d = 1'b1;
                end
                if (flush) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end
            end

            FLUSH: begin
                if (flush_cnt_q != CNT_LAST) begin
                    if (!m_valid || m_ready) begin
                        shift_en    = 1'b1;
                        shift_zero  = 1'b1;
                        m_valid_d   = 1'b1;
                        flush_cnt_d = sat_inc(flush_cnt_q);
                    end
                end else if (m_valid && m_ready) begin
                    clr          = 1'b1;
                    fill_cnt_d   = '0;
                    flush_cnt_d  = '0;
                    m_valid_d    = 1'b0;
                    flush_done_d = 1'b1;
                    state_d      = RST_STATE;
                end
            end

            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            fill_cnt_q  <= '0;
            flush_cnt_q <= '0;
            m_valid     <= 1'b0;
            flush_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            m_valid     <= m_valid_d;
            flush_done  <= flush_done_d;
        end
    end

    fir_shift_reg #(
        .DATA_W (DATA_W),
        .NTAPS  (NTAPS)
    ) u_window (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .shift_en (shift_en),
        .shift_in (shift_in),
        .taps     (taps)
    );

endmodule
